// File: rtl/mips_core_pkg.sv
// Shared core types for the issue queue scheduler.
// Sizes, tag/seq types and scheduler helpers.
package mips_core_pkg;

   localparam int IQ_ENTRIES = 32;
   localparam int IQ_IDX_W   = 5;
   localparam int PREG_W     = 6;
   localparam int IQ_SEQ_W   = 8;
   localparam int IQ_WAKEUP  = 2;

   typedef logic [IQ_IDX_W-1:0] iq_idx_t;
   typedef logic [PREG_W-1:0]   preg_t;
   typedef logic [IQ_SEQ_W-1:0] iq_seq_t;

   typedef enum logic {
      IQS_RUN,
      IQS_BLOCKED
   } iq_sched_state_e;

   // s is strictly younger than base within half the seq space
   function automatic logic seq_younger(
      input iq_seq_t s,
      input iq_seq_t base
   );
      iq_seq_t d;
      d = s - base;
      return (d != '0) && !d[IQ_SEQ_W-1];
   endfunction

   // tag matches any valid broadcast port
   function automatic logic tag_hit(
      input preg_t                         tag,
      input logic [IQ_WAKEUP-1:0]          v,
      input logic [IQ_WAKEUP*PREG_W-1:0]   tags
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < IQ_WAKEUP; k++)
         if (v[k] && tags[k*PREG_W +: PREG_W] == tag)
            hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue.
// older[i][j]=1 means entry i is older than entry j.
module iq_age_matrix
   import mips_core_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IQ_ENTRIES-1:0] alloc_oh,
   input  logic [IQ_ENTRIES-1:0] valid,
   input  logic [IQ_ENTRIES-1:0] free_mask,
   input  logic [IQ_ENTRIES-1:0] req,
   output logic [IQ_ENTRIES-1:0] oldest_oh
);

   logic [IQ_ENTRIES-1:0] older [IQ_ENTRIES];

   // new entry is younger than every surviving entry; freed rows/cols clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IQ_ENTRIES; i++)
            older[i] <= '0;
      end else begin
         for (int i = 0; i < IQ_ENTRIES; i++)
            for (int j = 0; j < IQ_ENTRIES; j++)
               if (alloc_oh[i])
                  older[i][j] <= 1'b0;
               else if (alloc_oh[j])
                  older[i][j] <= valid[i] & ~free_mask[i];
               else if (free_mask[i] || free_mask[j])
                  older[i][j] <= 1'b0;
      end
   end

   // a requester wins if no other requester is older than it
   always_comb begin
      oldest_oh = '0;
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         oldest_oh[i] = req[i];
         for (int j = 0; j < IQ_ENTRIES; j++)
            if (req[j] && older[j][i])
               oldest_oh[i] = 1'b0;
      end
   end

endmodule

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder.
// found=0 when no request bit is set.
module priority_encoder #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
) (
   input  logic [WIDTH-1:0] req,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // scan from the top so the lowest set bit wins
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (req[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
   end

endmodule

// File: rtl/iq_issue_scheduler.sv
// IQ slot allocator, wakeup tracker and oldest-first issue arbiter.
// Produces slot indices and control only; payload RAM lives outside.
module iq_issue_scheduler
   import mips_core_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alloc_valid,
   output logic                          alloc_ready,
   output logic [IQ_IDX_W-1:0]           alloc_idx,
   output logic [IQ_SEQ_W-1:0]           alloc_seq,
   input  logic                          alloc_uses_rs,
   input  logic [PREG_W-1:0]             alloc_rs_preg,
   input  logic                          alloc_rs_rdy,
   input  logic                          alloc_uses_rt,
   input  logic [PREG_W-1:0]             alloc_rt_preg,
   input  logic                          alloc_rt_rdy,
   input  logic [IQ_WAKEUP-1:0]          wakeup_valid,
   input  logic [IQ_WAKEUP*PREG_W-1:0]   wakeup_preg,
   output logic                          issue_valid,
   output logic [IQ_IDX_W-1:0]           issue_idx,
   output logic [IQ_SEQ_W-1:0]           issue_seq,
   input  logic                          issue_ready,
   input  logic                          flush_req,
   input  logic [IQ_SEQ_W-1:0]           flush_seq,
   input  logic                          flush_done,
   output logic [IQ_IDX_W:0]             occupancy
);

   logic [IQ_ENTRIES-1:0] valid_q;
   logic [IQ_ENTRIES-1:0] rs_rdy_q;
   logic [IQ_ENTRIES-1:0] rt_rdy_q;
   preg_t                 rs_preg_q [IQ_ENTRIES];
   preg_t                 rt_preg_q [IQ_ENTRIES];
   iq_seq_t               seq_q     [IQ_ENTRIES];
   iq_seq_t               seq_cnt_q;
   iq_sched_state_e       state_q;

   logic [IQ_ENTRIES-1:0] free_vec;
   logic [IQ_ENTRIES-1:0] squash;
   logic [IQ_ENTRIES-1:0] rdy_vec;
   logic [IQ_ENTRIES-1:0] oldest_oh;
   logic [IQ_ENTRIES-1:0] alloc_oh;
   logic [IQ_ENTRIES-1:0] issue_oh;
   logic [IQ_ENTRIES-1:0] free_mask;
   logic                  free_found;
   logic                  alloc_fire;
   logic                  issue_fire;

   assign free_vec = ~valid_q;

   priority_encoder #(
      .WIDTH (IQ_ENTRIES),
      .IDX_W (IQ_IDX_W)
   ) u_free_pe (
      .req   (free_vec),
      .idx   (alloc_idx),
      .found (free_found)
   );

   // squash set and ready set; younger entries never issue during flush
   always_comb begin
      squash  = '0;
      rdy_vec = '0;
      for (int i = 0; i < IQ_ENTRIES; i++) begin
         squash[i]  = flush_req & valid_q[i] &
                      seq_younger(seq_q[i], flush_seq);
         rdy_vec[i] = valid_q[i] & rs_rdy_q[i] &
                      rt_rdy_q[i] & ~squash[i];
      end
   end

   iq_age_matrix u_age (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc_oh  (alloc_oh),
      .valid     (valid_q),
      .free_mask (free_mask),
      .req       (rdy_vec),
      .oldest_oh (oldest_oh)
   );

   priority_encoder #(
      .WIDTH (IQ_ENTRIES),
      .IDX_W (IQ_IDX_W)
   ) u_issue_pe (
      .req   (oldest_oh),
      .idx   (issue_idx),
      .found (issue_valid)
   );

   assign issue_seq   = seq_q[issue_idx];
   assign alloc_seq   = seq_cnt_q;
   assign alloc_ready = free_found & (state_q == IQS_RUN) & ~flush_req;
   assign alloc_fire  = alloc_valid & alloc_ready;
   assign issue_fire  = issue_valid & issue_ready;
   assign alloc_oh    = alloc_fire ? (IQ_ENTRIES'(1) << alloc_idx) : '0;
   assign issue_oh    = issue_fire ? (IQ_ENTRIES'(1) << issue_idx) : '0;
   assign free_mask   = issue_oh | squash;

   // population count of valid entries
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < IQ_ENTRIES; i++)
         occupancy = occupancy + (IQ_IDX_W+1)'(valid_q[i]);
   end

   // entry state: fill on alloc (with bypass), free, wakeup
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         rs_rdy_q <= '0;
         rt_rdy_q <= '0;
         for (int i = 0; i < IQ_ENTRIES; i++) begin
            rs_preg_q[i] <= '0;
            rt_preg_q[i] <= '0;
            seq_q[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < IQ_ENTRIES; i++) begin
            if (alloc_oh[i]) begin
               valid_q[i]   <= 1'b1;
               rs_preg_q[i] <= alloc_rs_preg;
               rt_preg_q[i] <= alloc_rt_preg;
               seq_q[i]     <= seq_cnt_q;
               rs_rdy_q[i]  <= ~alloc_uses_rs | alloc_rs_rdy |
                  tag_hit(alloc_rs_preg, wakeup_valid, wakeup_preg);
               rt_rdy_q[i]  <= ~alloc_uses_rt | alloc_rt_rdy |
                  tag_hit(alloc_rt_preg, wakeup_valid, wakeup_preg);
            end else begin
               if (free_mask[i])
                  valid_q[i] <= 1'b0;
               if (tag_hit(rs_preg_q[i], wakeup_valid, wakeup_preg))
                  rs_rdy_q[i] <= 1'b1;
               if (tag_hit(rt_preg_q[i], wakeup_valid, wakeup_preg))
                  rt_rdy_q[i] <= 1'b1;
            end
         end
      end
   end

   // flush FSM and dispatch sequence counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IQS_RUN;
         seq_cnt_q <= '0;
      end else begin
         if (flush_req)
            seq_cnt_q <= flush_seq + 1'b1;
         else if (alloc_fire)
            seq_cnt_q <= seq_cnt_q + 1'b1;
         unique case (state_q)
            IQS_RUN:
               if (flush_req)
                  state_q <= IQS_BLOCKED;
            IQS_BLOCKED:
               if (!flush_req && flush_done)
                  state_q <= IQS_RUN;
            default:
               state_q <= IQS_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_iq_issue_scheduler.sv
// Directed bench for iq_issue_scheduler.
// Inputs change at negedge; outputs sampled 1ns later.
module tb_iq_issue_scheduler;

   logic        clk;
   logic        rst_n;
   logic        alloc_valid;
   logic        alloc_ready;
   logic [4:0]  alloc_idx;
   logic [7:0]  alloc_seq;
   logic        alloc_uses_rs;
   logic [5:0]  alloc_rs_preg;
   logic        alloc_rs_rdy;
   logic        alloc_uses_rt;
   logic [5:0]  alloc_rt_preg;
   logic        alloc_rt_rdy;
   logic [1:0]  wakeup_valid;
   logic [11:0] wakeup_preg;
   logic        issue_valid;
   logic [4:0]  issue_idx;
   logic [7:0]  issue_seq;
   logic        issue_ready;
   logic        flush_req;
   logic [7:0]  flush_seq;
   logic        flush_done;
   logic [5:0]  occupancy;

   int checks = 0;
   int errors = 0;

   iq_issue_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_valid   (alloc_valid),
      .alloc_ready   (alloc_ready),
      .alloc_idx     (alloc_idx),
      .alloc_seq     (alloc_seq),
      .alloc_uses_rs (alloc_uses_rs),
      .alloc_rs_preg (alloc_rs_preg),
      .alloc_rs_rdy  (alloc_rs_rdy),
      .alloc_uses_rt (alloc_uses_rt),
      .alloc_rt_preg (alloc_rt_preg),
      .alloc_rt_rdy  (alloc_rt_rdy),
      .wakeup_valid  (wakeup_valid),
      .wakeup_preg   (wakeup_preg),
      .issue_valid   (issue_valid),
      .issue_idx     (issue_idx),
      .issue_seq     (issue_seq),
      .issue_ready   (issue_ready),
      .flush_req     (flush_req),
      .flush_seq     (flush_seq),
      .flush_done    (flush_done),
      .occupancy     (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      alloc_valid   = 1'b0;
      alloc_uses_rs = 1'b0;
      alloc_rs_preg = '0;
      alloc_rs_rdy  = 1'b0;
      alloc_uses_rt = 1'b0;
      alloc_rt_preg = '0;
      alloc_rt_rdy  = 1'b0;
      wakeup_valid  = '0;
      wakeup_preg   = '0;
      issue_ready   = 1'b0;
      flush_req     = 1'b0;
      flush_seq     = '0;
      flush_done    = 1'b0;
   endtask

   task automatic do_reset();
      clr();
      rst_n = 1'b0;
      #7;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // one alloc handshake; called and returns at a negedge
   task automatic do_alloc(
      input logic       urs,
      input logic [5:0] rs,
      input logic       rsr,
      input logic       urt,
      input logic [5:0] rt,
      input logic       rtr,
      input int         eidx,
      input int         eseq
   );
      alloc_valid   = 1'b1;
      alloc_uses_rs = urs;
      alloc_rs_preg = rs;
      alloc_rs_rdy  = rsr;
      alloc_uses_rt = urt;
      alloc_rt_preg = rt;
      alloc_rt_rdy  = rtr;
      #1;
      chk("alloc_ready", 32'(alloc_ready), 1);
      chk("alloc_idx", 32'(alloc_idx), eidx);
      chk("alloc_seq", 32'(alloc_seq), eseq);
      @(negedge clk);
      alloc_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      clr();
      @(negedge clk);

      // 1: reset values, in-order alloc and issue
      do_reset();
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 0);
      chk("rst_occupancy", 32'(occupancy), 0);
      chk("rst_alloc_ready", 32'(alloc_ready), 1);
      chk("rst_alloc_idx", 32'(alloc_idx), 0);
      chk("rst_alloc_seq", 32'(alloc_seq), 0);
      for (int i = 0; i < 3; i++)
         do_alloc(1'b1, 6'd1, 1'b1, 1'b0, 6'd0, 1'b0, i, i);
      for (int i = 0; i < 3; i++) begin
         issue_ready = 1'b1;
         #1;
         chk("t1_issue_valid", 32'(issue_valid), 1);
         chk("t1_issue_idx", 32'(issue_idx), i);
         chk("t1_issue_seq", 32'(issue_seq), i);
         @(negedge clk);
      end
      issue_ready = 1'b0;
      #1;
      chk("t1_empty_valid", 32'(issue_valid), 0);
      chk("t1_empty_occ", 32'(occupancy), 0);

      // 2: waiting entry bypassed, then woken by port 1
      do_reset();
      do_alloc(1'b1, 6'd17, 1'b0, 1'b0, 6'd0, 1'b0, 0, 0);
      do_alloc(1'b1, 6'd5, 1'b1, 1'b1, 6'd6, 1'b1, 1, 1);
      #1;
      chk("t2_issue_valid", 32'(issue_valid), 1);
      chk("t2_issue_idx", 32'(issue_idx), 1);
      chk("t2_issue_seq", 32'(issue_seq), 1);
      issue_ready = 1'b1;
      @(negedge clk);
      issue_ready = 1'b0;
      #1;
      chk("t2_wait_valid", 32'(issue_valid), 0);
      wakeup_valid = 2'b10;
      wakeup_preg  = {6'd17, 6'd3};
      #1;
      chk("t2_bcast_cycle", 32'(issue_valid), 0);
      @(negedge clk);
      wakeup_valid = '0;
      #1;
      chk("t2_woken_valid", 32'(issue_valid), 1);
      chk("t2_woken_idx", 32'(issue_idx), 0);

      // 3: same-cycle wakeup bypass on alloc
      do_reset();
      wakeup_valid = 2'b01;
      wakeup_preg  = {6'd0, 6'd9};
      do_alloc(1'b1, 6'd9, 1'b0, 1'b0, 6'd0, 1'b0, 0, 0);
      wakeup_valid = 2'b10;
      wakeup_preg  = {6'd9, 6'd0};
      do_alloc(1'b1, 6'd12, 1'b0, 1'b1, 6'd13, 1'b0, 1, 1);
      wakeup_valid = '0;
      #1;
      chk("t3_bypass_valid", 32'(issue_valid), 1);
      chk("t3_bypass_idx", 32'(issue_idx), 0);
      issue_ready = 1'b1;
      @(negedge clk);
      issue_ready = 1'b0;
      #1;
      chk("t3_other_wait", 32'(issue_valid), 0);

      // 4: fill all 32 slots, free one
      do_reset();
      for (int i = 0; i < 32; i++)
         do_alloc(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, i, i);
      #1;
      chk("t4_full_ready", 32'(alloc_ready), 0);
      chk("t4_full_occ", 32'(occupancy), 32);
      chk("t4_oldest_idx", 32'(issue_idx), 0);
      issue_ready = 1'b1;
      alloc_valid = 1'b1;
      chk("t4_same_edge", 32'(alloc_ready), 0);
      @(negedge clk);
      issue_ready = 1'b0;
      alloc_valid = 1'b0;
      #1;
      chk("t4_after_occ", 32'(occupancy), 31);
      do_alloc(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 0, 32);
      #1;
      chk("t4_refill_occ", 32'(occupancy), 32);
      chk("t4_refill_ready", 32'(alloc_ready), 0);

      // 5: flush seq 8 out of 5..12
      do_reset();
      for (int i = 0; i < 5; i++)
         do_alloc(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, i, i);
      for (int i = 0; i < 5; i++) begin
         issue_ready = 1'b1;
         #1;
         chk("t5_drain_idx", 32'(issue_idx), i);
         @(negedge clk);
      end
      issue_ready = 1'b0;
      for (int i = 0; i < 8; i++)
         do_alloc(i != 5, 6'd63, 1'b0, 1'b0, 6'd0, 1'b0, i, 5 + i);
      #1;
      chk("t5_pre_occ", 32'(occupancy), 8);
      chk("t5_pre_idx", 32'(issue_idx), 5);
      chk("t5_pre_seq", 32'(issue_seq), 10);
      flush_req = 1'b1;
      flush_seq = 8'd8;
      #1;
      chk("t5_flush_mask", 32'(issue_valid), 0);
      chk("t5_flush_alloc", 32'(alloc_ready), 0);
      @(negedge clk);
      flush_req   = 1'b0;
      alloc_valid = 1'b1;
      #1;
      chk("t5_post_occ", 32'(occupancy), 4);
      chk("t5_blocked", 32'(alloc_ready), 0);
      chk("t5_post_valid", 32'(issue_valid), 0);
      @(negedge clk);
      alloc_valid = 1'b0;
      flush_done  = 1'b1;
      #1;
      chk("t5_refused_occ", 32'(occupancy), 4);
      chk("t5_done_cycle", 32'(alloc_ready), 0);
      @(negedge clk);
      flush_done = 1'b0;
      do_alloc(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 4, 9);

      // 6: wrap-around flush and flush_req+flush_done together
      do_reset();
      flush_req = 1'b1;
      flush_seq = 8'd249;
      @(negedge clk);
      flush_req  = 1'b0;
      flush_done = 1'b1;
      @(negedge clk);
      flush_done = 1'b0;
      for (int i = 0; i < 8; i++)
         do_alloc(1'b1, 6'd63, 1'b0, 1'b0, 6'd0, 1'b0, i, (250 + i) % 256);
      #1;
      chk("t6_pre_occ", 32'(occupancy), 8);
      flush_req = 1'b1;
      flush_seq = 8'd254;
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      chk("t6_post_occ", 32'(occupancy), 5);
      flush_req  = 1'b1;
      flush_done = 1'b1;
      @(negedge clk);
      flush_req  = 1'b0;
      flush_done = 1'b0;
      #1;
      chk("t6_still_blocked", 32'(alloc_ready), 0);
      chk("t6_resquash_occ", 32'(occupancy), 5);
      flush_done = 1'b1;
      @(negedge clk);
      flush_done = 1'b0;
      do_alloc(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 5, 255);
      #1;
      chk("t6_final_occ", 32'(occupancy), 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
